multichannel_sample_buffer: RTL and testbench
=============================================

Name: multichannel_sample_buffer

Overview:
Parametrised per-channel sample history buffer. Each channel keeps the last DEPTH samples in a circular buffer with its own write pointer and fill count. A single random-access read port returns any stored sample by channel and age, one cycle after the request. Sits between the input sampling front-end (ui_in) and downstream filter/readout logic.

Parameters:
NUM_CHANNELS, 14, number of independent channels (>=1)
SAMPLE_WIDTH, 8, bits per sample
DEPTH, 10, samples retained per channel (>=2, need not be a power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  write strobe, one sample per cycle
in_channel  in  CH_W  target channel of write
in_sample  in  SAMPLE_WIDTH  sample data
clr_valid  in  1  clear strobe
clr_channel  in  CH_W  channel to clear
rd_req  in  1  read request
rd_channel  in  CH_W  channel to read
rd_index  in  IDX_W  sample age: 0 = newest
rd_valid  out  1  read response valid
rd_data  out  SAMPLE_WIDTH  read sample
rd_miss  out  1  requested sample not present
rd_sum  out  SUM_W  channel running sum (see Optional Feature)
full_flags  out  NUM_CHANNELS  bit c = channel c holds DEPTH samples
err  out  1  sticky: out-of-range write/clear channel seen

Behaviour:
- Reset: all wr_ptr, count, sum = 0; rd_valid, rd_data, rd_miss, rd_sum, full_flags, err = 0. Sample storage is not reset.
- Write: in_valid with in_channel < NUM_CHANNELS stores at wr_ptr[ch]; wr_ptr increments, wrapping DEPTH-1 -> 0; count increments, saturating at DEPTH (oldest sample overwritten).
- Write or clear with channel >= NUM_CHANNELS: no state change; err set, held until reset.
- Clear: clears wr_ptr, count, and sum of clr_channel; stored data is untouched but unreachable.
- Clear and write to the same channel in the same cycle: clear is applied first, then the write: count=1, wr_ptr=1, newest = written sample.
- Read: rd_req sampled at edge N; rd_valid=1 in cycle N+1 only, with rd_data/rd_miss/rd_sum. Slot = (wr_ptr-1-rd_index) mod DEPTH, computed with a conditional add of DEPTH (no modulo operator).
- rd_miss=1 and rd_data=0 if rd_index >= count[ch] or rd_channel >= NUM_CHANNELS.
- Read and write to the same channel in the same cycle: read returns pre-write state.
- Without rd_req: rd_valid=0; rd_data and rd_miss hold their last values.
- full_flags registered, updated in the same cycle as count.
- Reset asserted mid-operation overrides all strobes in that cycle.

Optional Feature:
Macro SAMPLE_BUF_SUM_EN.
- Defined: per-channel running sum of the stored samples, SUM_W = SAMPLE_WIDTH + $clog2(DEPTH+1). On each write, sum += new - evicted, where evicted = old slot value if count==DEPTH, else 0. Clear sets sum to 0; clear+write sets sum to the new sample. rd_sum returns the channel's sum alongside rd_data, and is 0 on a miss caused by an invalid channel.
- Undefined: no sum registers; rd_sum tied to 0; port list is unchanged.

Decomposition:
- Package sample_buf_pkg: CH_W = $clog2(NUM_CHANNELS) (min 1), IDX_W = $clog2(DEPTH), SUM_W function, and ring slot-index helper function.
- Sub-module sample_buf_channel (one ring: storage, wr_ptr, count, optional sum, clear/write precedence), generated NUM_CHANNELS times.
- Top level handles channel decode, err, the read mux and output registers.

Test Plan:
1. Reset, then read ch0 idx0 -> next cycle rd_valid=1, rd_miss=1, rd_data=0x00; full_flags=0.
2. Write 0x11,0x22,0x33 to ch3 -> idx0=0x33, idx2=0x11, idx3 miss; rd_sum=0x66 (SUM_EN).
3. Write 1..12 to ch5 -> full_flags[5]=1 after the 10th write; idx0=12, idx9=3; rd_sum=75 (SUM_EN). Ch3 data unchanged.
4. Same-cycle write 0x44 to ch3 and read ch3 idx0 -> 0x33; next read idx0 -> 0x44, idx1 -> 0x33.
5. Write and clear with channel 14 -> no state change; err=1; err stays 1 through further valid traffic until reset.
6. Same-cycle clear ch5 and write 0x7F to ch5 -> idx0=0x7F, idx1 miss, full_flags[5]=0, rd_sum=0x7F. Then assert reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sample_buf_pkg.sv
// Shared widths and ring-index arithmetic for the multichannel sample buffer.
// Optional running-sum feature: SAMPLE_BUF_SUM_EN.
package sample_buf_pkg;

  // Channel-select width. A single channel still needs a 1-bit select.
  function automatic int ch_w(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  // The fill count must be able to reach DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int sum_w(input int sample_width, input int depth);
    return sample_width + $clog2(depth + 1);
  endfunction

  // Storage slot holding the sample 'age' writes old. This is only meaningful
  // when age < count <= depth, so wr_ptr - 1 - age >= -depth, and a single
  // conditional add wraps it back into the ring.
  function automatic int ring_slot(input int wr_ptr, input int age, input int depth);
    int slot;
    slot = wr_ptr - 1 - age;
    if (slot < 0) slot = slot + depth;
    return slot;
  endfunction

endpackage

// File: rtl/sample_buf_channel.sv
// One channel's ring: storage, write pointer, fill count and full flag, plus an
// optional running sum (SAMPLE_BUF_SUM_EN). Clear takes effect before a same-cycle write.
module sample_buf_channel
  import sample_buf_pkg::*;
#(
  parameter int  SAMPLE_WIDTH = 8,
  parameter int  DEPTH        = 10,
  localparam int IDX_W        = idx_w(DEPTH),
  localparam int CNT_W        = cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [SAMPLE_WIDTH-1:0] wr_sample,
  input  logic                    clr_en,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_hit,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    full
`ifdef SAMPLE_BUF_SUM_EN
  ,
  output logic [sum_w(SAMPLE_WIDTH, DEPTH)-1:0] rd_sum
`endif
);

  logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]        wr_ptr_q, wr_ptr_d, ptr_base;
  logic [CNT_W-1:0]        count_q, count_d, cnt_base;
  logic                    full_q;
  logic [IDX_W-1:0]        rd_slot;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ptr_base = clr_en ? '0 : wr_ptr_q;
    cnt_base = clr_en ? '0 : count_q;
    wr_ptr_d = ptr_base;
    count_d  = cnt_base;
    if (wr_en) begin
      wr_ptr_d = (ptr_base == IDX_W'(DEPTH - 1)) ? '0 : ptr_base + IDX_W'(1);
      if (cnt_base != CNT_W'(DEPTH)) count_d = cnt_base + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
    end
  end

  // NOTE: sample storage is deliberately not reset; the zeroed count makes
  // stale entries unreachable, and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[ptr_base] <= wr_sample;
  end

  always_comb begin
    rd_hit  = int'(rd_idx) < int'(count_q);
    rd_slot = rd_hit ? IDX_W'(ring_slot(int'(wr_ptr_q), int'(rd_idx), DEPTH)) : '0;
    rd_data = rd_hit ? mem_q[rd_slot] : '0;
  end

  assign full = full_q;

`ifdef SAMPLE_BUF_SUM_EN
  localparam int SUM_W = sum_w(SAMPLE_WIDTH, DEPTH);

  logic [SUM_W-1:0]        sum_q, sum_d, sum_base;
  logic [SAMPLE_WIDTH-1:0] evicted;

  // Only a full ring loses a sample on write; that sample sits at the write slot.
  always_comb begin
    sum_base = clr_en ? '0 : sum_q;
    evicted  = '0;
    sum_d    = sum_base;
    if (wr_en) begin
      if (cnt_base == CNT_W'(DEPTH)) evicted = mem_q[ptr_base];
      sum_d = sum_base + SUM_W'(wr_sample) - SUM_W'(evicted);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign rd_sum = sum_q;
`endif

endmodule

// File: rtl/multichannel_sample_buffer.sv
// Per-channel sample history with one registered random-access read port.
// Optional per-channel running sum on rd_sum: SAMPLE_BUF_SUM_EN (else rd_sum = 0).
module multichannel_sample_buffer
  import sample_buf_pkg::*;
#(
  parameter int  NUM_CHANNELS = 14,
  parameter int  SAMPLE_WIDTH = 8,
  parameter int  DEPTH        = 10,
  localparam int CH_W         = ch_w(NUM_CHANNELS),
  localparam int IDX_W        = idx_w(DEPTH),
  localparam int SUM_W        = sum_w(SAMPLE_WIDTH, DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_channel,
  input  logic [SAMPLE_WIDTH-1:0] in_sample,
  input  logic                    clr_valid,
  input  logic [CH_W-1:0]         clr_channel,
  input  logic                    rd_req,
  input  logic [CH_W-1:0]         rd_channel,
  input  logic [IDX_W-1:0]        rd_index,
  output logic                    rd_valid,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_miss,
  output logic [SUM_W-1:0]        rd_sum,
  output logic [NUM_CHANNELS-1:0] full_flags,
  output logic                    err
);

  logic                    wr_ok, clr_ok, rd_ok;
  logic [NUM_CHANNELS-1:0] chan_wr, chan_clr, chan_hit, chan_full;
  logic [SAMPLE_WIDTH-1:0] chan_data [NUM_CHANNELS];
`ifdef SAMPLE_BUF_SUM_EN
  logic [SUM_W-1:0]        chan_sum  [NUM_CHANNELS];
`endif

  assign wr_ok  = int'(in_channel)  < NUM_CHANNELS;
  assign clr_ok = int'(clr_channel) < NUM_CHANNELS;
  assign rd_ok  = int'(rd_channel)  < NUM_CHANNELS;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign chan_wr[c]  = in_valid  && wr_ok  && (in_channel  == CH_W'(c));
    assign chan_clr[c] = clr_valid && clr_ok && (clr_channel == CH_W'(c));

    sample_buf_channel #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .DEPTH        (DEPTH)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (chan_wr[c]),
      .wr_sample (in_sample),
      .clr_en    (chan_clr[c]),
      .rd_idx    (rd_index),
      .rd_hit    (chan_hit[c]),
      .rd_data   (chan_data[c]),
      .full      (chan_full[c])
`ifdef SAMPLE_BUF_SUM_EN
      ,
      .rd_sum    (chan_sum[c])
`endif
    );
  end

  logic [CH_W-1:0]         rd_sel;
  logic [SAMPLE_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                    rd_miss_d, rd_miss_q, rd_valid_q;
  logic                    err_d, err_q;

  // An out-of-range read channel is steered to channel 0 and forced to a miss.
  always_comb begin
    rd_sel    = rd_ok ? rd_channel : '0;
    rd_data_d = '0;
    rd_miss_d = 1'b1;
    if (rd_ok) begin
      rd_data_d = chan_data[rd_sel];
      rd_miss_d = !chan_hit[rd_sel];
    end
    err_d = err_q | (in_valid & ~wr_ok) | (clr_valid & ~clr_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_miss_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      err_q      <= err_d;
      if (rd_req) begin
        rd_data_q <= rd_data_d;
        rd_miss_q <= rd_miss_d;
      end
    end
  end

`ifdef SAMPLE_BUF_SUM_EN
  logic [SUM_W-1:0] rd_sum_q;

  always_ff @(posedge clk) begin
    if (reset)       rd_sum_q <= '0;
    else if (rd_req) rd_sum_q <= rd_ok ? chan_sum[rd_sel] : '0;
  end

  assign rd_sum = rd_sum_q;
`else
  assign rd_sum = '0;
`endif

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_miss    = rd_miss_q;
  assign full_flags = chan_full;
  assign err        = err_q;

endmodule

// File: tb/tb_multichannel_sample_buffer.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based history model.
module tb_multichannel_sample_buffer;

  localparam int NCH   = 14;
  localparam int SW    = 8;
  localparam int DEPTH = 10;
  localparam int CH_W  = 4;
  localparam int IDX_W = 4;
  localparam int SUM_W = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [CH_W-1:0]  in_channel = '0;
  logic [SW-1:0]    in_sample = '0;
  logic             clr_valid = 1'b0;
  logic [CH_W-1:0]  clr_channel = '0;
  logic             rd_req = 1'b0;
  logic [CH_W-1:0]  rd_channel = '0;
  logic [IDX_W-1:0] rd_index = '0;
  logic             rd_valid;
  logic [SW-1:0]    rd_data;
  logic             rd_miss;
  logic [SUM_W-1:0] rd_sum;
  logic [NCH-1:0]   full_flags;
  logic             err;

  always #5 clk = ~clk;

  multichannel_sample_buffer #(
    .NUM_CHANNELS (NCH),
    .SAMPLE_WIDTH (SW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_channel  (in_channel),
    .in_sample   (in_sample),
    .clr_valid   (clr_valid),
    .clr_channel (clr_channel),
    .rd_req      (rd_req),
    .rd_channel  (rd_channel),
    .rd_index    (rd_index),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_miss     (rd_miss),
    .rd_sum      (rd_sum),
    .full_flags  (full_flags),
    .err         (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per channel, retained samples newest-first.
  logic [SW-1:0]    hist [NCH][$];
  logic             exp_err  = 1'b0;
  logic [SW-1:0]    exp_data = '0;
  logic             exp_miss = 1'b0;
  logic [SUM_W-1:0] exp_sum  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sum(input int ch);
    int s;
    s = 0;
`ifdef SAMPLE_BUF_SUM_EN
    foreach (hist[ch][k]) s += int'(hist[ch][k]);
`endif
    return s;
  endfunction

  function automatic logic [NCH-1:0] model_full();
    logic [NCH-1:0] f;
    for (int c = 0; c < NCH; c++) f[c] = (hist[c].size() == DEPTH);
    return f;
  endfunction

  task automatic cycle(input logic wv, input int wch, input logic [SW-1:0] ws,
                       input logic cv, input int cch,
                       input logic rq, input int rch, input int ridx);
    @(negedge clk);
    in_valid    = wv;
    in_channel  = CH_W'(wch);
    in_sample   = ws;
    clr_valid   = cv;
    clr_channel = CH_W'(cch);
    rd_req      = rq;
    rd_channel  = CH_W'(rch);
    rd_index    = IDX_W'(ridx);
    // Read response reflects the state before this cycle's clear/write.
    if (rq) begin
      if (rch >= NCH) begin
        exp_data = '0;
        exp_miss = 1'b1;
        exp_sum  = '0;
      end else begin
        exp_sum = SUM_W'(model_sum(rch));
        if (ridx < hist[rch].size()) begin
          exp_data = hist[rch][ridx];
          exp_miss = 1'b0;
        end else begin
          exp_data = '0;
          exp_miss = 1'b1;
        end
      end
    end
    @(posedge clk);
    if (cv) begin
      if (cch < NCH) hist[cch].delete();
      else           exp_err = 1'b1;
    end
    if (wv) begin
      if (wch < NCH) begin
        hist[wch].push_front(ws);
        if (hist[wch].size() > DEPTH) void'(hist[wch].pop_back());
      end else begin
        exp_err = 1'b1;
      end
    end
    #1;
    check("rd_valid", 32'(rd_valid), 32'(rq));
    check("rd_data", 32'(rd_data), 32'(exp_data));
    check("rd_miss", 32'(rd_miss), 32'(exp_miss));
    if (rq) check("rd_sum", 32'(rd_sum), 32'(exp_sum));
    check("full_flags", 32'(full_flags), 32'(model_full()));
    check("err", 32'(err), 32'(exp_err));
  endtask

  task automatic wr(input int ch, input logic [SW-1:0] s);
    cycle(1'b1, ch, s, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic rd(input int ch, input int idx);
    cycle(1'b0, 0, '0, 1'b0, 0, 1'b1, ch, idx);
  endtask

  // Reset with random strobes active: reset must win over all of them.
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    in_valid    = 1'($urandom_range(0, 1));
    in_channel  = CH_W'($urandom_range(0, 15));
    in_sample   = SW'($urandom);
    clr_valid   = 1'($urandom_range(0, 1));
    clr_channel = CH_W'($urandom_range(0, 15));
    rd_req      = 1'b1;
    rd_channel  = CH_W'($urandom_range(0, NCH - 1));
    rd_index    = IDX_W'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) hist[c].delete();
    exp_err  = 1'b0;
    exp_data = '0;
    exp_miss = 1'b0;
    exp_sum  = '0;
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_rd_miss", 32'(rd_miss), 32'(0));
    check("rst_rd_sum", 32'(rd_sum), 32'(0));
    check("rst_full_flags", 32'(full_flags), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    clr_valid = 1'b0;
    rd_req    = 1'b0;
  endtask

  initial begin
    do_reset();

    // Empty buffer reads miss with zero data.
    rd(0, 0);

    // Partial fill of channel 3.
    wr(3, 8'h11);
    wr(3, 8'h22);
    wr(3, 8'h33);
    rd(3, 0);
    rd(3, 2);
    rd(3, 3);

    // Overfill channel 5 past DEPTH; full flag and eviction.
    for (int v = 1; v <= 12; v++) wr(5, SW'(v));
    rd(5, 0);
    rd(5, 9);
    rd(5, 10);
    rd(3, 0);

    // Same-cycle write and read: read sees pre-write history.
    cycle(1'b1, 3, 8'h44, 1'b0, 0, 1'b1, 3, 0);
    rd(3, 0);
    rd(3, 1);

    // Out-of-range write and clear; error stays sticky.
    cycle(1'b1, 14, 8'hAA, 1'b1, 14, 1'b0, 0, 0);
    rd(3, 0);
    wr(2, 8'h55);
    rd(15, 0);
    cycle(1'b1, 15, 8'h01, 1'b0, 0, 1'b1, 2, 0);

    // Clear and write to the same channel in one cycle.
    cycle(1'b1, 5, 8'h7F, 1'b1, 5, 1'b0, 0, 0);
    rd(5, 0);
    rd(5, 1);
    wr(4, 8'h09);
    do_reset();
    rd(5, 0);

    // Random traffic, biased toward a few channels so rings wrap.
    for (int i = 0; i < 2000; i++) begin
      int wch, cch, rch;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        wch = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
        cch = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
        rch = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
        cycle(1'($urandom_range(0, 9) < 6), wch, SW'($urandom),
              1'($urandom_range(0, 29) == 0), cch,
              1'($urandom_range(0, 9) < 7), rch, int'($urandom_range(0, 15)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
